if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
Instruction-fetch stage directly upstream of the IF/ID pipeline register. Owns the program counter and runs a request/acknowledge handshake to instruction memory. Splits each returned 32-bit word into opcode/rd/rs/rt/imm/jaddr fields plus a return PC, which feed the IF/ID register's inputs. Honours hazard-unit stall and branch/jump redirect, and emits bubbles (opcode 5'b11111) when no valid instruction is available.

Parameters:
RESET_PC, 32'd0, word address loaded into the PC on reset
NOP_OPCODE, 5'b11111, bubble opcode driven when Valid=0

Ports:
clk  input  1  clock
Reset  input  1  synchronous, active-high reset
Stall  input  1  hazard hold: do not advance PC or change the field outputs
Redirect  input  1  taken branch/jump this cycle; load Target into PC
Target  input  32  redirect word address
Imem_req  output  1  fetch request, level, held until ack
Imem_addr  output  32  word address of the request (= PC)
Imem_ack  input  1  instruction data valid this cycle
Imem_rdata  input  32  instruction word
Opcode  output  5  instr[31:27]; NOP_OPCODE when Valid=0
Rd  output  5  instr[26:22]
Rs  output  5  instr[21:17]
Rt  output  5  instr[16:12]
Imm  output  17  instr[16:0]
Jaddr  output  32  {Pc[31:27], instr[26:0]}
Pc  output  32  fetched address + 1 (sequential return PC)
Valid  output  1  field outputs hold a real instruction

Behaviour:
- Reset (any state, including mid-request): PC=RESET_PC; state=REQ; drop flag cleared; Opcode=NOP_OPCODE; Rd/Rs/Rt=0; Imm=0; Jaddr=0; Pc=0; Valid=0. Memory discards any outstanding request on Reset.
- PC is word-addressed; sequential increment is +1, mod 2^32, so 32'hFFFFFFFF wraps to 0.
- Field outputs are registered. Imem_req and Imem_addr are decoded from state and PC.
- States: REQ, HOLD.
- REQ state:
  - Imem_req=1 and Imem_addr=PC.
  - Imem_ack is sampled at the clock edge. Ack in the first cycle gives a 1-cycle fetch; each extra wait cycle adds 1.
  - If the cycle ends without an ack, the fields are set to a bubble (Valid=0, Opcode=NOP_OPCODE), unless Stall=1, in which case they hold.
- Ack in REQ with Stall=0, Redirect=0, drop=0:
  - Capture the fields from Imem_rdata; Pc<=PC+1; Valid<=1; PC<=PC+1.
  - Stay in REQ, so back-to-back fetches give 1 instruction/cycle with a zero-wait memory.
- Ack in REQ with Stall=1, Redirect=0, drop=0:
  - Capture the word into an internal hold register, keep the field outputs unchanged, go to HOLD.
  - PC is not advanced yet.
- HOLD state:
  - Imem_req=0.
  - When Stall drops, present the held word on the fields with Valid=1, set PC<=PC+1, and return to REQ.
- Redirect (priority over Stall and ack):
  - PC<=Target; next field outputs are a bubble; state goes to REQ; the HOLD contents are discarded.
  - If a request is outstanding without ack in that cycle, set drop=1.
  - An ack arriving in the same cycle as Redirect is discarded.
- drop=1: the next ack is discarded (fields become a bubble) and drop is cleared. Imem_req stays 1 with the new Imem_addr. The memory must return data in request order.
- Stall with no ack in REQ: the request stays asserted and the field outputs hold.

Optional Feature:
IF_PERF_CNT_EN
- Defined:
  - Adds output port FetchCount[31:0], a counter of instructions delivered with Valid=1 and not discarded.
  - Adds output port StallCycles[31:0], counting cycles with Stall=1.
  - Both counters clear on Reset and wrap at 2^32.
- Undefined: neither port nor the counters exist; all other behaviour is identical.

Decomposition:
- Shared package if_pkg holds:
  - The field bit positions (OPC_HI=31, OPC_LO=27, RD 26:22, RS 21:17, RT 16:12, IMM 16:0, JIDX 26:0).
  - NOP_OPCODE.
  - The state encoding (REQ=1'b0, HOLD=1'b1).
- The IF/ID register and the decode stage use the same package constants.
- One sub-module is natural: if_field_split, a combinational 32-bit word to opcode/rd/rs/rt/imm/jaddr splitter, shared by the capture path and the HOLD-release path.

Test Plan:
1. Reset then zero-wait memory returning 32'h0840_0000, 32'h1000_0005, ... → Imem_addr 0,1,2 on consecutive cycles. First output: Opcode=5'd1, Rd=5'd1, Pc=1, Valid=1 the cycle after ack.
2. Two-cycle wait memory → Imem_req held at addr 0 for 2 cycles; fields show a bubble (Opcode=5'b11111, Valid=0) until the ack is captured.
3. Ack arriving with Stall=1 for 3 cycles → field outputs unchanged, no new request, PC=0. After Stall drops, the held word appears with Pc=1 and Imem_addr becomes 1.
4. Redirect to Target=32'h40 while a request to addr 5 awaits ack → the late ack is discarded (bubble); next request at addr 32'h40; the delivered instruction has Pc=32'h41.
5. PC=32'hFFFF_FFFF fetch → Pc output 0 and next Imem_addr 0. With instr[26:0]=27'h123 and the delivered Pc=0, Jaddr=32'h0000_0123.
6. Reset asserted mid-request and mid-HOLD → next cycle Imem_addr=RESET_PC, Valid=0, Opcode=5'b11111. With IF_PERF_CNT_EN defined, FetchCount=0.

Source files
------------

// File: rtl/if_pkg.sv
// if_pkg: shared constants for the fetch stage, IF/ID register and decode.
//   - instruction field bit positions
//   - bubble opcode
//   - fetch FSM state encoding
//   - if_fields_t: the split instruction fields plus return PC
package if_pkg;

  localparam int OPC_HI  = 31;
  localparam int OPC_LO  = 27;
  localparam int RD_HI   = 26;
  localparam int RD_LO   = 22;
  localparam int RS_HI   = 21;
  localparam int RS_LO   = 17;
  localparam int RT_HI   = 16;
  localparam int RT_LO   = 12;
  localparam int IMM_HI  = 16;
  localparam int IMM_LO  = 0;
  localparam int JIDX_HI = 26;
  localparam int JIDX_LO = 0;

  localparam logic [4:0] NOP_OPCODE = 5'b11111;

  typedef enum logic {
    ST_REQ  = 1'b0,
    ST_HOLD = 1'b1
  } if_state_e;

  typedef struct packed {
    logic [4:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [16:0] imm;
    logic [31:0] jaddr;
    logic [31:0] pc;
  } if_fields_t;

endpackage

// File: rtl/if_fetch_unit_field_split.sv
// if_field_split: combinational splitter of a 32-bit instruction word.
//   instr  : instruction word
//   ret_pc : sequential return PC (fetched address + 1)
//   fields : opcode/rd/rs/rt/imm/jaddr/pc
// Jaddr takes its upper bits from the return PC, not the fetched address.
module if_field_split
  import if_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] ret_pc,
  output if_fields_t  fields
);

  always_comb begin
    fields        = '0;
    fields.opcode = instr[OPC_HI:OPC_LO];
    fields.rd     = instr[RD_HI:RD_LO];
    fields.rs     = instr[RS_HI:RS_LO];
    fields.rt     = instr[RT_HI:RT_LO];
    fields.imm    = instr[IMM_HI:IMM_LO];
    fields.jaddr  = {ret_pc[31:27], instr[JIDX_HI:JIDX_LO]};
    fields.pc     = ret_pc;
  end

endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage feeding the IF/ID register.
//   clk, Reset (sync, active-high)
//   Stall, Redirect, Target        : hazard hold / branch-jump redirect
//   Imem_req, Imem_addr            : level request to imem (word address)
//   Imem_ack, Imem_rdata           : returned instruction
//   Opcode/Rd/Rs/Rt/Imm/Jaddr/Pc   : registered split fields, Valid qualifies
// Optional macro IF_PERF_CNT_EN adds FetchCount and StallCycles counters.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'd0,
  parameter logic [4:0]  NOP_OPCODE = if_pkg::NOP_OPCODE
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] Target,
  output logic        Imem_req,
  output logic [31:0] Imem_addr,
  input  logic        Imem_ack,
  input  logic [31:0] Imem_rdata,
  output logic [4:0]  Opcode,
  output logic [4:0]  Rd,
  output logic [4:0]  Rs,
  output logic [4:0]  Rt,
  output logic [16:0] Imm,
  output logic [31:0] Jaddr,
  output logic [31:0] Pc,
`ifdef IF_PERF_CNT_EN
  output logic [31:0] FetchCount,
  output logic [31:0] StallCycles,
`endif
  output logic        Valid
);

  import if_pkg::*;

  localparam if_fields_t BUBBLE = '{opcode: NOP_OPCODE, rd: 5'd0, rs: 5'd0,
                                    rt: 5'd0, imm: 17'd0, jaddr: 32'd0,
                                    pc: 32'd0};

  if_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        drop_q, drop_d;
  logic [31:0] hold_q, hold_d;
  if_fields_t  fld_q, fld_d;
  logic        valid_q, valid_d;

  logic [31:0] pc_plus1;
  logic [31:0] src_word;
  if_fields_t  split;
  logic        deliver;

  assign pc_plus1 = pc_q + 32'd1;
  // One splitter serves both the direct-capture and HOLD-release paths.
  assign src_word = (state_q == ST_HOLD) ? hold_q : Imem_rdata;

  if_field_split u_split (
    .instr  (src_word),
    .ret_pc (pc_plus1),
    .fields (split)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drop_d  = drop_q;
    hold_d  = hold_q;
    fld_d   = fld_q;
    valid_d = valid_q;
    deliver = 1'b0;
    if (Redirect) begin
      pc_d    = Target;
      state_d = ST_REQ;
      fld_d   = BUBBLE;
      valid_d = 1'b0;
      // An unacked request is still in flight at the memory; its data must
      // be thrown away when it arrives. A same-cycle ack is simply ignored.
      drop_d  = (state_q == ST_REQ) && !Imem_ack;
    end else if (state_q == ST_REQ) begin
      if (Imem_ack && drop_q) begin
        drop_d = 1'b0;
        if (!Stall) begin
          fld_d   = BUBBLE;
          valid_d = 1'b0;
        end
      end else if (Imem_ack && !Stall) begin
        fld_d   = split;
        valid_d = 1'b1;
        pc_d    = pc_plus1;
        deliver = 1'b1;
      end else if (Imem_ack) begin
        // Park the word; PC advances only when it is actually delivered.
        hold_d  = Imem_rdata;
        state_d = ST_HOLD;
      end else if (!Stall) begin
        fld_d   = BUBBLE;
        valid_d = 1'b0;
      end
    end else if (!Stall) begin
      fld_d   = split;
      valid_d = 1'b1;
      pc_d    = pc_plus1;
      state_d = ST_REQ;
      deliver = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q <= ST_REQ;
      pc_q    <= RESET_PC;
      drop_q  <= 1'b0;
      hold_q  <= 32'd0;
      fld_q   <= BUBBLE;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
      hold_q  <= hold_d;
      fld_q   <= fld_d;
      valid_q <= valid_d;
    end
  end

  assign Imem_req  = (state_q == ST_REQ);
  assign Imem_addr = pc_q;
  assign Opcode    = fld_q.opcode;
  assign Rd        = fld_q.rd;
  assign Rs        = fld_q.rs;
  assign Rt        = fld_q.rt;
  assign Imm       = fld_q.imm;
  assign Jaddr     = fld_q.jaddr;
  assign Pc        = fld_q.pc;
  assign Valid     = valid_q;

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q + {31'd0, deliver};
    stall_cnt_d = stall_cnt_q + {31'd0, Stall};
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      fetch_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign FetchCount  = fetch_cnt_q;
  assign StallCycles = stall_cnt_q;
`else
  logic unused_deliver;
  assign unused_deliver = deliver;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed stimulus pushes hand-computed expected
// instructions into a scoreboard; a monitor pops and compares each delivery.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        Reset, Stall, Redirect, Imem_ack;
  logic [31:0] Target, Imem_rdata;
  logic        Imem_req, Valid;
  logic [31:0] Imem_addr, Jaddr, Pc;
  logic [4:0]  Opcode, Rd, Rs, Rt;
  logic [16:0] Imm;
`ifdef IF_PERF_CNT_EN
  logic [31:0] FetchCount, StallCycles;
`endif

  if_fetch_unit dut (
    .clk(clk), .Reset(Reset), .Stall(Stall), .Redirect(Redirect),
    .Target(Target), .Imem_req(Imem_req), .Imem_addr(Imem_addr),
    .Imem_ack(Imem_ack), .Imem_rdata(Imem_rdata), .Opcode(Opcode),
    .Rd(Rd), .Rs(Rs), .Rt(Rt), .Imm(Imm), .Jaddr(Jaddr), .Pc(Pc),
`ifdef IF_PERF_CNT_EN
    .FetchCount(FetchCount), .StallCycles(StallCycles),
`endif
    .Valid(Valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  opc, rd, rs, rt;
    logic [16:0] imm;
    logic [31:0] jaddr, pc;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic st_edge = 1'b1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic push(input logic [4:0] opc, rd, rs, rt, input logic [16:0] imm,
                      input logic [31:0] jaddr, pc);
    exp_t e;
    e.opc = opc; e.rd = rd; e.rs = rs; e.rt = rt;
    e.imm = imm; e.jaddr = jaddr; e.pc = pc;
    sb.push_back(e);
  endtask

  // Monitor: a new instruction is on the fields whenever Valid is high and
  // the preceding edge had Stall low (under Stall the fields merely hold).
  always @(posedge clk) st_edge <= Stall;

  always @(negedge clk) begin
    if (Valid === 1'b1 && st_edge === 1'b0) begin
      if (sb.size() == 0) begin
        chk("unexpected_delivery_pc", Pc, 32'hxxxx_xxxx);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("opcode", {27'd0, Opcode}, {27'd0, e.opc});
        chk("rd",     {27'd0, Rd},     {27'd0, e.rd});
        chk("rs",     {27'd0, Rs},     {27'd0, e.rs});
        chk("rt",     {27'd0, Rt},     {27'd0, e.rt});
        chk("imm",    {15'd0, Imm},    {15'd0, e.imm});
        chk("jaddr",  Jaddr,           e.jaddr);
        chk("pc",     Pc,              e.pc);
      end
    end
  end

  // One cycle: check request side and (optionally) a bubble on the fields,
  // then drive this cycle's inputs.
  task automatic step(input logic st, input logic rdr, input logic [31:0] tgt,
                      input logic ack, input logic [31:0] data,
                      input logic exp_req, input logic [31:0] exp_addr,
                      input logic exp_bub);
    @(negedge clk);
    chk("imem_req", {31'd0, Imem_req}, {31'd0, exp_req});
    if (exp_req) chk("imem_addr", Imem_addr, exp_addr);
    if (exp_bub) begin
      chk("bubble_valid",  {31'd0, Valid},  32'd0);
      chk("bubble_opcode", {27'd0, Opcode}, 32'd31);
    end
    Stall = st; Redirect = rdr; Target = tgt; Imem_ack = ack; Imem_rdata = data;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_valid"},  {31'd0, Valid},  32'd0);
    chk({tag, "_opcode"}, {27'd0, Opcode}, 32'd31);
    chk({tag, "_addr"},   Imem_addr,       32'd0);
    chk({tag, "_req"},    {31'd0, Imem_req}, 32'd1);
    chk({tag, "_pc"},     Pc,              32'd0);
`ifdef IF_PERF_CNT_EN
    chk({tag, "_fetchcnt"}, FetchCount, 32'd0);
`endif
  endtask

  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

  initial begin
    Reset = 1'b1; Stall = 1'b0; Redirect = 1'b0; Target = 32'd0;
    Imem_ack = 1'b0; Imem_rdata = 32'd0;
    repeat (2) @(negedge clk);
    chk_reset_state("reset");
    chk("reset_rd", {27'd0, Rd}, 32'd0);
    chk("reset_jaddr", Jaddr, 32'd0);
    Reset = 1'b0;

    // Zero-wait memory: addr 0,1,2 back to back.
    step(0, 0, 0, 1, 32'h0840_0000, 1, 32'd0, 1);
    push(5'd1, 5'd1, 5'd0, 5'd0, 17'd0, 32'h0040_0000, 32'd1);
    step(0, 0, 0, 1, 32'h1000_0005, 1, 32'd1, 0);
    push(5'd2, 5'd0, 5'd0, 5'd0, 17'd5, 32'h0000_0005, 32'd2);
    step(0, 0, 0, 1, 32'h2A5A_5A5A, 1, 32'd2, 0);
    push(5'd5, 5'd9, 5'd13, 5'd5, 17'h05A5A, 32'h025A_5A5A, 32'd3);

    // Two wait cycles at addr 3: request held, bubbles on the fields.
    step(0, 0, 0, 0, 32'd0, 1, 32'd3, 0);
    step(0, 0, 0, 0, 32'd0, 1, 32'd3, 1);
    step(0, 0, 0, 1, 32'h1800_0000, 1, 32'd3, 1);
    push(5'd3, 5'd0, 5'd0, 5'd0, 17'd0, 32'd0, 32'd4);

    // Ack under Stall: word parked, no request for 3 stalled cycles.
    step(1, 0, 0, 1, 32'h2000_0000, 1, 32'd4, 0);
    push(5'd4, 5'd0, 5'd0, 5'd0, 17'd0, 32'd0, 32'd5);
    step(1, 0, 0, 0, 32'd0, 0, 32'd0, 0);
    step(1, 0, 0, 0, 32'd0, 0, 32'd0, 0);
    step(0, 0, 0, 0, 32'd0, 0, 32'd0, 0);
    step(0, 0, 0, 0, 32'd0, 1, 32'd5, 0);

    // Redirect to 0x40 while addr 5 is outstanding: late ack dropped.
    step(0, 1, 32'h40, 0, 32'd0, 1, 32'd5, 1);
    step(0, 0, 0, 1, JUNK, 1, 32'h40, 1);
    step(0, 0, 0, 1, 32'h2800_0000, 1, 32'h40, 1);
    push(5'd5, 5'd0, 5'd0, 5'd0, 17'd0, 32'd0, 32'h41);

    // Redirect with a same-cycle ack: that ack is ignored, no drop pending.
    step(0, 1, 32'h80, 1, JUNK, 1, 32'h41, 0);
    step(0, 0, 0, 1, 32'h3000_0000, 1, 32'h80, 1);
    push(5'd6, 5'd0, 5'd0, 5'd0, 17'd0, 32'd0, 32'h81);

    // PC wrap at 0xFFFF_FFFF.
    step(0, 1, 32'hFFFF_FFFF, 1, JUNK, 1, 32'h81, 0);
    step(0, 0, 0, 1, 32'h3800_0123, 1, 32'hFFFF_FFFF, 1);
    push(5'd7, 5'd0, 5'd0, 5'd0, 17'h00123, 32'h0000_0123, 32'd0);
    step(0, 0, 0, 0, 32'd0, 1, 32'd0, 0);

    // Reset mid-request (outstanding at 0x10).
    step(0, 1, 32'h10, 1, JUNK, 1, 32'd0, 1);
    step(0, 0, 0, 0, 32'd0, 1, 32'h10, 1);
    @(negedge clk);
    chk("midreq_addr", Imem_addr, 32'h10);
    Reset = 1'b1; Stall = 1'b0; Redirect = 1'b0; Imem_ack = 1'b0;
    @(negedge clk);
    chk_reset_state("rst_midreq");
    Reset = 1'b0;

    // Reset mid-HOLD.
    step(1, 0, 0, 1, JUNK, 1, 32'd0, 1);
    @(negedge clk);
    chk("hold_req", {31'd0, Imem_req}, 32'd0);
    Reset = 1'b1; Stall = 1'b0; Imem_ack = 1'b0;
    @(negedge clk);
    chk_reset_state("rst_hold");
    Reset = 1'b0;

    // Normal fetch after reset recovers.
    step(0, 0, 0, 1, 32'h0840_0000, 1, 32'd0, 1);
    push(5'd1, 5'd1, 5'd0, 5'd0, 17'd0, 32'h0040_0000, 32'd1);
    step(0, 0, 0, 0, 32'd0, 1, 32'd1, 0);
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
